// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush/halt sequencer for the 5-stage WISC-15 pipeline (IF ID EX MEM WB).
//   Detects load-use hazards, squashes wrong-path work on EX redirects, freezes
//   the pipe while data memory is busy and drains in-flight work after HLT.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   id_opcode/rs/rt     decoded fields of the instruction in ID
//   id_valid            ID holds a real instruction (not a bubble)
//   ex_mem_read, ex_rd  EX holds a LW and its destination register
//   ex_redirect         EX resolved a taken branch/call/ret this cycle
//   mem_busy            data memory not ready, MEM must hold
//   pc_stall            hold PC
//   ifid_stall          hold IF/ID
//   ifid_flush          load NOP into IF/ID
//   idex_flush          load bubble into ID/EX
//   exmem_stall         hold ID/EX, EX/MEM and MEM/WB
//   halted              registered, high once the drain after HLT completes
//   stall_count         saturating count of cycles spent with pc_stall high
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_opcode,
  input  logic [3:0]       id_rs,
  input  logic [3:0]       id_rt,
  input  logic             id_valid,
  input  logic             ex_mem_read,
  input  logic [3:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DCW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_INIT = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DCW-1:0]   r_drain_cnt;
  logic [DCW-1:0]   w_drain_nxt;
  logic             r_halted;
  logic [CNT_W-1:0] r_stall_count;

  logic w_rs_used;
  logic w_rt_used;
  logic w_load_use;
  logic w_hlt;
  logic w_drain_last;

  // Source-operand usage by opcode class; 1010-1111 read no registers.
  assign w_rs_used  = (id_opcode <= 4'd9);
  assign w_rt_used  = (id_opcode <= 4'd4) || (id_opcode == 4'd9);

  // R0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign w_load_use = id_valid & ex_mem_read & (ex_rd != 4'd0) &
                      ((w_rs_used & (ex_rd == id_rs)) |
                       (w_rt_used & (ex_rd == id_rt)));

  assign w_hlt = id_valid & (id_opcode == 4'hF);

  // The HLT cycle plus DRAIN_CYCLES-1 drain cycles make halted rise exactly
  // DRAIN_CYCLES edges after HLT sat in ID: leave DRAIN on the cycle whose
  // decrement reaches zero.
  assign w_drain_last = (r_drain_cnt == DCW'(0)) || (r_drain_cnt == DCW'(1));

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    case (r_state)
      ST_RUN: begin
        if (mem_busy) begin
          // Redirect is held in EX and re-evaluated once memory is ready.
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          exmem_stall = 1'b1;
        end else if (ex_redirect) begin
          // Also squashes a HLT sitting in ID, so no drain starts.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (w_load_use) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end else if (w_hlt) begin
          pc_stall    = 1'b1;
          ifid_flush  = 1'b1;
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = DRAIN_INIT;
        end
      end
      ST_DRAIN: begin
        // Nothing younger than HLT is live, so ex_redirect is ignored here.
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (mem_busy) begin
          ifid_stall  = 1'b1;
          exmem_stall = 1'b1;
        end else if (w_drain_last) begin
          w_state_nxt = ST_HALTED;
          w_drain_nxt = '0;
        end else begin
          w_drain_nxt = r_drain_cnt - DCW'(1);
        end
      end
      ST_HALTED: begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        exmem_stall = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_drain_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_drain_cnt   <= '0;
      r_halted      <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_halted    <= (w_state_nxt == ST_HALTED);
      // Halted cycles are not counted; the counter saturates instead of wrapping.
      if (pc_stall && (r_state != ST_HALTED) && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign halted      = r_halted;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  id_opcode = '0, id_rs = '0, id_rt = '0, ex_rd = '0;
  logic        id_valid = 1'b0, ex_mem_read = 1'b0, ex_redirect = 1'b0, mem_busy = 1'b0;

  logic        pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall, halted;
  logic [15:0] stall_count;
  logic        pc_stall4, ifid_stall4, ifid_flush4, idex_flush4, exmem_stall4, halted4;
  logic [3:0]  stall_count4;

  int checks   = 0;
  int failures = 0;

  // Expected {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall, halted}
  localparam logic [5:0] E_IDLE  = 6'b000000;
  localparam logic [5:0] E_LU    = 6'b110100;
  localparam logic [5:0] E_BUSY  = 6'b110010;
  localparam logic [5:0] E_REDIR = 6'b001100;
  localparam logic [5:0] E_HLT   = 6'b101000;
  localparam logic [5:0] E_DRN   = 6'b101100;
  localparam logic [5:0] E_DRNB  = 6'b111110;
  localparam logic [5:0] E_HALT  = 6'b110011;

  typedef struct packed {
    logic [3:0] op, rs, rt;
    logic       v, mr;
    logic [3:0] rd;
    logic       redir, busy;
    logic [5:0] exp;
  } stim_t;

  logic [5:0] sb[$];
  logic [15:0] m16;
  logic [3:0]  m4;

  wire [5:0] w_obs  = {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall, halted};
  wire [5:0] w_obs4 = {pc_stall4, ifid_stall4, ifid_flush4, idex_flush4, exmem_stall4, halted4};

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_valid(id_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_stall(exmem_stall), .halted(halted), .stall_count(stall_count)
  );

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_valid(id_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .pc_stall(pc_stall4),
    .ifid_stall(ifid_stall4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
    .exmem_stall(exmem_stall4), .halted(halted4), .stall_count(stall_count4)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic [3:0] op, rs, rt, input logic v, mr,
                               input logic [3:0] rd, input logic redir, busy,
                               input logic [5:0] exp);
    stim_t s;
    s.op = op; s.rs = rs; s.rt = rt; s.v = v; s.mr = mr; s.rd = rd;
    s.redir = redir; s.busy = busy; s.exp = exp;
    return s;
  endfunction

  // Drive one cycle of inputs and record the expected strobes.
  task automatic drive(input stim_t s);
    id_opcode = s.op; id_rs = s.rs; id_rt = s.rt; id_valid = s.v;
    ex_mem_read = s.mr; ex_rd = s.rd; ex_redirect = s.redir; mem_busy = s.busy;
    sb.push_back(s.exp);
  endtask

  task automatic idle_inputs();
    id_opcode = '0; id_rs = '0; id_rt = '0; id_valid = 1'b0;
    ex_mem_read = 1'b0; ex_rd = '0; ex_redirect = 1'b0; mem_busy = 1'b0;
  endtask

  // Bench-side stall counter model: counts cycles expected to stall the PC
  // outside HALTED, saturating at the counter width.
  task automatic model_count(input logic [5:0] e);
    if (e[5] && !e[0]) begin
      if (m16 != 16'hFFFF) m16 = m16 + 16'd1;
      if (m4  != 4'hF)     m4  = m4 + 4'd1;
    end
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m16 = '0; m4 = '0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({w_obs, w_obs4} !== {E_IDLE, E_IDLE}) begin
      failures++;
      $display("FAIL reset_strobes actual=%b/%b required=%b", w_obs, w_obs4, E_IDLE);
    end
    checks++;
    if (stall_count !== 16'd0 || stall_count4 !== 4'd0) begin
      failures++;
      $display("FAIL reset_count actual=%0d/%0d required=0", stall_count, stall_count4);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m16 = '0; m4 = '0;
  endtask

  task automatic test_load_use();
    stim_t t[$];
    logic [5:0] e;
    t.push_back(mk(4'h0, 4'h3, 4'h0, 1, 1, 4'h3, 0, 0, E_LU));    // ADD rs=R3 after LW R3
    t.push_back(mk(4'h0, 4'h3, 4'h0, 1, 0, 4'h3, 0, 0, E_IDLE));  // load advanced
    t.push_back(mk(4'h1, 4'h0, 4'h5, 1, 1, 4'h5, 0, 0, E_LU));    // rt match, opcode 0001
    t.push_back(mk(4'h9, 4'h2, 4'h7, 1, 1, 4'h7, 0, 0, E_LU));    // rt match, opcode 1001
    t.push_back(mk(4'h5, 4'h0, 4'h5, 1, 1, 4'h5, 0, 0, E_IDLE));  // 0101 does not read rt
    t.push_back(mk(4'h8, 4'h6, 4'h0, 1, 1, 4'h6, 0, 0, E_LU));    // rs match, opcode 1000
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, E_IDLE));
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({w_obs, w_obs4} !== {e, e}) begin
        failures++;
        $display("FAIL load_use[%0d] strobes actual=%b/%b required=%b", i, w_obs, w_obs4, e);
      end
      checks++;
      if (stall_count !== m16 || stall_count4 !== m4) begin
        failures++;
        $display("FAIL load_use[%0d] count actual=%0d/%0d required=%0d/%0d", i, stall_count, stall_count4, m16, m4);
      end
      model_count(e);
    end
  endtask

  task automatic test_no_hazard();
    stim_t t[$];
    logic [5:0] e;
    t.push_back(mk(4'h0, 4'h0, 4'h0, 1, 1, 4'h0, 0, 0, E_IDLE));  // LW R0 never hazards
    t.push_back(mk(4'hC, 4'h3, 4'h3, 1, 1, 4'h3, 0, 0, E_IDLE));  // B reads no regs
    t.push_back(mk(4'hA, 4'h3, 4'h3, 1, 1, 4'h3, 0, 0, E_IDLE));
    t.push_back(mk(4'h0, 4'h3, 4'h3, 0, 1, 4'h3, 0, 0, E_IDLE));  // bubble in ID
    t.push_back(mk(4'h0, 4'h3, 4'h4, 1, 1, 4'h5, 0, 0, E_IDLE));  // no register match
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, E_IDLE));
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({w_obs, w_obs4} !== {e, e}) begin
        failures++;
        $display("FAIL no_hazard[%0d] strobes actual=%b/%b required=%b", i, w_obs, w_obs4, e);
      end
      checks++;
      if (stall_count !== m16 || stall_count4 !== m4) begin
        failures++;
        $display("FAIL no_hazard[%0d] count actual=%0d/%0d required=%0d/%0d", i, stall_count, stall_count4, m16, m4);
      end
      model_count(e);
    end
  endtask

  task automatic test_priority();
    stim_t t[$];
    logic [5:0] e;
    t.push_back(mk(4'h0, 4'h3, 4'h0, 1, 1, 4'h3, 1, 0, E_REDIR)); // redirect beats load-use
    t.push_back(mk(4'h0, 4'h3, 4'h0, 1, 1, 4'h3, 1, 1, E_BUSY));  // busy beats redirect
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 1, E_BUSY));  // busy alone
    t.push_back(mk(4'hF, 4'h0, 4'h0, 1, 0, 4'h0, 1, 0, E_REDIR)); // HLT squashed by redirect
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, E_IDLE));  // still RUN, no drain
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, E_IDLE));
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({w_obs, w_obs4} !== {e, e}) begin
        failures++;
        $display("FAIL priority[%0d] strobes actual=%b/%b required=%b", i, w_obs, w_obs4, e);
      end
      checks++;
      if (stall_count !== m16 || stall_count4 !== m4) begin
        failures++;
        $display("FAIL priority[%0d] count actual=%0d/%0d required=%0d/%0d", i, stall_count, stall_count4, m16, m4);
      end
      model_count(e);
    end
  endtask

  task automatic test_halt();
    stim_t t[$];
    logic [5:0] e;
    t.push_back(mk(4'hF, 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, E_HLT));   // HLT in ID
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, E_DRN));
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 1, 0, E_DRN));   // redirect ignored in drain
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, E_DRN));
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, E_HALT));  // 4th edge after HLT
    t.push_back(mk(4'h0, 4'h3, 4'h0, 1, 1, 4'h3, 1, 0, E_HALT));  // frozen regardless of inputs
    t.push_back(mk(4'hF, 4'h0, 4'h0, 1, 0, 4'h0, 0, 1, E_HALT));
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({w_obs, w_obs4} !== {e, e}) begin
        failures++;
        $display("FAIL halt[%0d] strobes actual=%b/%b required=%b", i, w_obs, w_obs4, e);
      end
      checks++;
      if (stall_count !== m16 || stall_count4 !== m4) begin
        failures++;
        $display("FAIL halt[%0d] count actual=%0d/%0d required=%0d/%0d", i, stall_count, stall_count4, m16, m4);
      end
      model_count(e);
    end
    pulse_rst();
  endtask

  task automatic test_halt_busy();
    stim_t t[$];
    logic [5:0] e;
    t.push_back(mk(4'hF, 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, E_HLT));
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, E_DRN));
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 1, E_DRNB));  // 3 busy cycles freeze drain
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 1, E_DRNB));
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 1, E_DRNB));
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, E_DRN));
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, E_DRN));
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, E_HALT));  // 7 cycles after HLT
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({w_obs, w_obs4} !== {e, e}) begin
        failures++;
        $display("FAIL halt_busy[%0d] strobes actual=%b/%b required=%b", i, w_obs, w_obs4, e);
      end
      checks++;
      if (stall_count !== m16 || stall_count4 !== m4) begin
        failures++;
        $display("FAIL halt_busy[%0d] count actual=%0d/%0d required=%0d/%0d", i, stall_count, stall_count4, m16, m4);
      end
      model_count(e);
    end
    pulse_rst();
  endtask

  task automatic test_rst_in_drain();
    stim_t t[$];
    logic [5:0] e;
    // Enter DRAIN, then hit reset mid-drain.
    @(posedge clk); #1;
    drive(mk(4'hF, 4'h0, 4'h0, 1, 0, 4'h0, 0, 0, E_HLT));
    @(posedge clk); #1;
    drive(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, E_DRN));
    @(negedge clk);
    e = sb.pop_front();
    e = sb.pop_front();
    checks++;
    if ({w_obs, w_obs4} !== {e, e}) begin
      failures++;
      $display("FAIL rst_drain pre strobes actual=%b/%b required=%b", w_obs, w_obs4, e);
    end
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    #2;
    checks++;
    if ({w_obs, w_obs4} !== {E_IDLE, E_IDLE} || stall_count !== 16'd0 || stall_count4 !== 4'd0) begin
      failures++;
      $display("FAIL rst_drain async strobes=%b count=%0d required=%b count=0", w_obs, stall_count, E_IDLE);
    end
    rst = 1'b0;
    m16 = '0; m4 = '0;
    // Back in RUN: load-use works, then idle shows no lingering drain.
    t.push_back(mk(4'h0, 4'h3, 4'h0, 1, 1, 4'h3, 0, 0, E_LU));
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, E_IDLE));
    t.push_back(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, E_IDLE));
    foreach (t[i]) begin
      @(posedge clk); #1;
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({w_obs, w_obs4} !== {e, e}) begin
        failures++;
        $display("FAIL rst_drain[%0d] strobes actual=%b/%b required=%b", i, w_obs, w_obs4, e);
      end
      checks++;
      if (stall_count !== m16 || stall_count4 !== m4) begin
        failures++;
        $display("FAIL rst_drain[%0d] count actual=%0d/%0d required=%0d/%0d", i, stall_count, stall_count4, m16, m4);
      end
      model_count(e);
    end
  endtask

  task automatic test_saturate();
    logic [5:0] e;
    pulse_rst();
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      if (i < 20) drive(mk(4'h0, 4'h3, 4'h0, 1, 1, 4'h3, 0, 0, E_LU));
      else        drive(mk(4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, E_IDLE));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({w_obs, w_obs4} !== {e, e}) begin
        failures++;
        $display("FAIL saturate[%0d] strobes actual=%b/%b required=%b", i, w_obs, w_obs4, e);
      end
      checks++;
      if (stall_count !== m16 || stall_count4 !== m4) begin
        failures++;
        $display("FAIL saturate[%0d] count actual=%0d/%0d required=%0d/%0d", i, stall_count, stall_count4, m16, m4);
      end
      model_count(e);
    end
    checks++;
    if (stall_count4 !== 4'd15 || stall_count !== 16'd20) begin
      failures++;
      $display("FAIL saturate_final actual=%0d/%0d required=15/20", stall_count4, stall_count);
    end
  endtask

  initial begin
    m16 = '0; m4 = '0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_priority();
    test_halt();
    test_halt_busy();
    test_rst_in_drain();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/halt sequencer for the 5-stage WISC-15 pipeline (IF, ID, EX, MEM, WB). It consumes decoded information from ID, EX and MEM and produces per-stage stall and flush strobes. It detects load-use hazards, flushes wrong-path instructions on taken branch/call/ret, and freezes the pipe while data memory is busy. It also runs the halt drain sequence that retires in-flight instructions before asserting `halted`.

Parameters:
DRAIN_CYCLES, 4, cycles from HLT leaving ID until `halted` asserts (EX+MEM+WB+1 retire slack).
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
id_opcode  input  4  opcode of the instruction in ID
id_rs  input  4  rs field in ID
id_rt  input  4  rt field in ID
id_valid  input  1  ID holds a real (non-bubble) instruction
ex_mem_read  input  1  instruction in EX is LW
ex_rd  input  4  destination register of the EX instruction
ex_redirect  input  1  EX resolved a taken branch, call or ret (PC redirect this cycle)
mem_busy  input  1  data memory not ready; MEM stage must hold
pc_stall  output  1  hold PC
ifid_stall  output  1  hold IF/ID register
ifid_flush  output  1  load NOP into IF/ID
idex_flush  output  1  load bubble into ID/EX
exmem_stall  output  1  hold ID/EX, EX/MEM and MEM/WB
halted  output  1  processor halted (registered)
stall_count  output  CNT_W  saturating count of cycles with pc_stall=1 (registered)

Behaviour:
- Reset (async, rst=1): state=RUN, drain_cnt=0, halted=0, stall_count=0. Strobe outputs are combinational; with all inputs 0 they are 0.
- Source-use decode in ID:
  - rs_used for opcodes 0000–1001.
  - rt_used for opcodes 0000–0100 and 1001.
  - Neither is used for 1010–1111.
- load_use = id_valid & ex_mem_read & (ex_rd != 0) & ((rs_used & ex_rd==id_rs) | (rt_used & ex_rd==id_rt)). R0 never causes a hazard.
- Strobe priority in RUN, highest first:
  1. mem_busy: pc_stall, ifid_stall and exmem_stall = 1; no flush asserted, even if ex_redirect is set. The redirect is held in EX and re-evaluated.
  2. ex_redirect: ifid_flush=1, idex_flush=1, no stalls. A HLT sitting in ID is squashed and does not start a drain.
  3. load_use: pc_stall=1, ifid_stall=1, idex_flush=1. Fixed 1-cycle bubble; the hazard clears when the load advances.
  4. HLT in ID (id_valid & id_opcode==1111) with none of the above: pc_stall=1, ifid_flush=1. The HLT itself passes to EX. Next state=DRAIN, drain_cnt=DRAIN_CYCLES-1.
- FSM states: RUN, DRAIN, HALTED.
  - DRAIN:
    - pc_stall=1 and ifid_flush=1 every cycle; idex_flush=1 (no new work enters EX).
    - mem_busy additionally asserts exmem_stall/ifid_stall and freezes drain_cnt.
    - Otherwise drain_cnt decrements by 1 per cycle. At drain_cnt==0 with !mem_busy, next state=HALTED.
    - ex_redirect is ignored in DRAIN, since nothing younger than HLT is live.
  - HALTED:
    - halted=1, pc_stall=1, ifid_stall=1, exmem_stall=1, all flushes=0.
    - Left only by rst.
- halted is registered: it asserts on the first clock edge that enters HALTED, exactly DRAIN_CYCLES cycles after the HLT cycle in ID when there are no memory waits.
- stall_count increments on every rising edge where pc_stall=1 and state!=HALTED. It saturates at all-ones and does not wrap.
- Reset asserted mid-DRAIN or in HALTED returns immediately to RUN with all counters cleared.

Test Plan:
1. LW R3 in EX (ex_mem_read=1, ex_rd=3), ADD in ID with id_rs=3 -> one cycle of pc_stall=1, ifid_stall=1, idex_flush=1; next cycle (ex_mem_read=0) all strobes 0; stall_count=1.
2. Same as 1 but ex_rd=0, or the ID opcode is 1100 (b) -> no stall; stall_count unchanged.
3. ex_redirect=1 together with load_use=1 -> ifid_flush=1, idex_flush=1, pc_stall=0. Repeat with mem_busy=1 -> pc_stall=1, exmem_stall=1, no flushes.
4. HLT in ID, mem_busy=0 throughout -> pc_stall=1 for 4 cycles; halted rises at the 4th edge after the HLT cycle; outputs then frozen in the HALTED pattern.
5. HLT drain with mem_busy=1 for 3 cycles mid-drain -> halted is delayed by exactly 3 cycles. Pulse rst during DRAIN -> halted=0, stall_count=0, state RUN.
6. With CNT_W=4, hold load_use for 20 cycles -> stall_count stops at 15.
